// File: rtl/pcs_descrambler_if.sv
// Block-stream bundle between gearbox, descrambler and 64b/66b decoder.
// DIN_EN qualifies DIN for exactly one cycle; there is no backpressure, and DOUT_EN qualifies DOUT/DOUT_SH the same way.
interface pcs_descrambler_if;
    logic        CSR_PCS_DESCRAMB_DIS;
    logic        DIN_EN;
    logic [65:0] DIN;
    logic [63:0] DOUT;
    logic [1:0]  DOUT_SH;
    logic        DOUT_EN;
    logic        BLOCK_LOCK;
    logic        SLIP;
    logic        SH_ERR;
    logic [1:0]  DBG_STATE;

    modport master (
        output CSR_PCS_DESCRAMB_DIS, DIN_EN, DIN,
        input  DOUT, DOUT_SH, DOUT_EN, BLOCK_LOCK, SLIP, SH_ERR, DBG_STATE
    );

    modport slave (
        input  CSR_PCS_DESCRAMB_DIS, DIN_EN, DIN,
        output DOUT, DOUT_SH, DOUT_EN, BLOCK_LOCK, SLIP, SH_ERR, DBG_STATE
    );
endinterface

// File: rtl/pcs_descrambler.sv
// Receive 64b/66b PCS: sync-header block lock with gearbox slip, plus
// self-synchronizing 1 + x^39 + x^58 payload descrambler.
module pcs_descrambler #(
    parameter int LOCK_CNT   = 64,
    parameter int WINDOW     = 64,
    parameter int ERR_THRESH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    pcs_descrambler_if.slave bus
);
    localparam int SHW  = $clog2(LOCK_CNT) + 1;
    localparam int WINW = $clog2(WINDOW) + 1;
    localparam int ERRW = $clog2(ERR_THRESH) + 1;

    typedef enum logic [1:0] {
        ST_UNLOCKED  = 2'd0,
        ST_SLIP_WAIT = 2'd1,
        ST_LOCKED    = 2'd2
    } state_t;

    state_t          r_state;
    logic [SHW-1:0]  r_sh_cnt;
    logic [WINW-1:0] r_win_cnt;
    logic [ERRW-1:0] r_err_cnt;
    logic            r_skip;
    logic [57:0]     r_s;
    logic [63:0]     r_dout;
    logic [1:0]      r_dout_sh;
    logic            r_dout_en;
    logic            r_lock;
    logic            r_slip;
    logic            r_sh_err;

    logic [63:0]     w_p;
    logic [121:0]    w_h;
    logic [63:0]     w_desc;
    logic            w_sh_valid;
    logic [SHW-1:0]  w_sh_cnt_nx;
    logic [WINW-1:0] w_win_nx;
    logic [ERRW-1:0] w_err_nx;

    assign w_p         = bus.DIN[65:2];
    assign w_h         = {w_p, r_s};
    assign w_sh_valid  = bus.DIN[0] ^ bus.DIN[1];
    assign w_sh_cnt_nx = r_sh_cnt + SHW'(1);
    assign w_win_nx    = r_win_cnt + WINW'(1);
    assign w_err_nx    = r_err_cnt + ERRW'(!w_sh_valid);

    // Each output bit taps the received bits 39 and 58 positions earlier in the stream.
    always_comb begin
        w_desc = '0;
        for (int i = 0; i < 64; i++) begin
            w_desc[i] = w_p[i] ^ w_h[i+19] ^ w_h[i];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_s       <= '1;
            r_dout    <= '0;
            r_dout_sh <= '0;
            r_dout_en <= 1'b0;
        end else begin
            r_dout_en <= bus.DIN_EN;
            if (bus.DIN_EN) begin
                r_dout_sh <= bus.DIN[1:0];
                if (bus.CSR_PCS_DESCRAMB_DIS) begin
                    r_dout <= w_p;
                end else begin
                    r_dout <= w_desc;
                    r_s    <= w_p[63:6];
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_UNLOCKED;
            r_sh_cnt  <= '0;
            r_win_cnt <= '0;
            r_err_cnt <= '0;
            r_skip    <= 1'b0;
            r_lock    <= 1'b0;
            r_slip    <= 1'b0;
            r_sh_err  <= 1'b0;
        end else begin
            r_slip   <= 1'b0;
            r_sh_err <= 1'b0;
            if (bus.DIN_EN) begin
                case (r_state)
                    ST_UNLOCKED: begin
                        if (w_sh_valid) begin
                            if (w_sh_cnt_nx == SHW'(LOCK_CNT)) begin
                                r_state   <= ST_LOCKED;
                                r_lock    <= 1'b1;
                                r_sh_cnt  <= '0;
                                r_win_cnt <= '0;
                                r_err_cnt <= '0;
                            end else begin
                                r_sh_cnt <= w_sh_cnt_nx;
                            end
                        end else begin
                            r_slip   <= 1'b1;
                            r_sh_err <= 1'b1;
                            r_sh_cnt <= '0;
                            r_skip   <= 1'b0;
                            r_state  <= ST_SLIP_WAIT;
                        end
                    end
                    // Two blocks are discarded while the gearbox realigns.
                    ST_SLIP_WAIT: begin
                        if (r_skip) begin
                            r_skip  <= 1'b0;
                            r_state <= ST_UNLOCKED;
                        end else begin
                            r_skip <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        r_sh_err <= !w_sh_valid;
                        if (w_err_nx == ERRW'(ERR_THRESH)) begin
                            r_lock    <= 1'b0;
                            r_slip    <= 1'b1;
                            r_win_cnt <= '0;
                            r_err_cnt <= '0;
                            r_sh_cnt  <= '0;
                            r_skip    <= 1'b0;
                            r_state   <= ST_SLIP_WAIT;
                        end else if (w_win_nx == WINW'(WINDOW)) begin
                            r_win_cnt <= '0;
                            r_err_cnt <= '0;
                        end else begin
                            r_win_cnt <= w_win_nx;
                            r_err_cnt <= w_err_nx;
                        end
                    end
                    default: begin
                        r_state <= ST_UNLOCKED;
                    end
                endcase
            end
        end
    end

    assign bus.DOUT       = r_dout;
    assign bus.DOUT_SH    = r_dout_sh;
    assign bus.DOUT_EN    = r_dout_en;
    assign bus.BLOCK_LOCK = r_lock;
    assign bus.SLIP       = r_slip;
    assign bus.SH_ERR     = r_sh_err;
    assign bus.DBG_STATE  = r_state;
endmodule

// File: tb/tb_pcs_descrambler.sv
// Bench for pcs_descrambler: bit-stream reference scrambler/descrambler and
// per-scenario lock expectations derived from block indices.
module tb_pcs_descrambler;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pcs_descrambler_if u_if();

    pcs_descrambler #(
        .LOCK_CNT  (64),
        .WINDOW    (64),
        .ERR_THRESH(16)
    ) u_dut (
        .CLK(clk),
        .RST(rst),
        .bus(u_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bit          rx_q[$];
    bit          tx_q[$];
    logic [63:0] exp_q[$];

    function automatic logic [63:0] rnd64();
        return {32'($urandom), 32'($urandom)};
    endfunction

    function automatic logic [1:0] rnd_valid_sh();
        return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic void rx_seed();
        rx_q.delete();
        repeat (58) rx_q.push_back(1'b1);
    endfunction

    function automatic void tx_seed(input bit v);
        tx_q.delete();
        repeat (58) tx_q.push_back(v);
    endfunction

    // Reference descrambler over the received bit stream (first bit = p[0]).
    function automatic logic [63:0] model_desc(input logic [63:0] p);
        logic [63:0] r;
        int n;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            n = rx_q.size();
            r[i] = p[i] ^ rx_q[n-39] ^ rx_q[n-58];
            rx_q.push_back(p[i]);
        end
        while (rx_q.size() > 58) void'(rx_q.pop_front());
        return r;
    endfunction

    // Reference transmit scrambler: the history holds scrambled bits.
    function automatic logic [63:0] tx_scramble(input logic [63:0] d);
        logic [63:0] r;
        int n;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            n = tx_q.size();
            r[i] = d[i] ^ tx_q[n-39] ^ tx_q[n-58];
            tx_q.push_back(r[i]);
        end
        while (tx_q.size() > 58) void'(tx_q.pop_front());
        return r;
    endfunction

    // Inputs change on the falling edge; outputs are observed on the next falling edge.
    task automatic step(input logic en, input logic [1:0] sh, input logic [63:0] p);
        u_if.DIN_EN = en;
        u_if.DIN    = {p, sh};
        @(negedge clk);
    endtask

    task automatic do_reset();
        u_if.DIN_EN = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rx_seed();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        u_if.DIN_EN = 1'b1;
        u_if.DIN = {rnd64(), 2'b11};
        repeat (3) @(negedge clk);
        n_tests++;
        if (u_if.DOUT !== 64'h0) begin
            n_fail++; $display("FAIL reset_dout got %h exp 0", u_if.DOUT);
        end
        n_tests++;
        if (u_if.DOUT_SH !== 2'b00) begin
            n_fail++; $display("FAIL reset_dout_sh got %b exp 00", u_if.DOUT_SH);
        end
        n_tests++;
        if ({u_if.DOUT_EN, u_if.BLOCK_LOCK, u_if.SLIP, u_if.SH_ERR} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags got %b exp 0000",
                {u_if.DOUT_EN, u_if.BLOCK_LOCK, u_if.SLIP, u_if.SH_ERR});
        end
        u_if.DIN_EN = 1'b0;
        rst = 1'b0;
        rx_seed();
        @(negedge clk);
    endtask

    task automatic test_loopback();
        logic [63:0] base, p, e;
        do_reset();
        tx_seed(1'b1);
        base = rnd64();
        for (int k = 0; k < 100; k++) begin
            p = base + 64'(k);
            exp_q.push_back(p);
            step(1'b1, 2'b01, tx_scramble(p));
            e = exp_q.pop_front();
            n_tests++;
            if (u_if.DOUT !== e) begin
                n_fail++; $display("FAIL loop_dout blk %0d got %h exp %h", k, u_if.DOUT, e);
            end
            n_tests++;
            if (u_if.DOUT_SH !== 2'b01) begin
                n_fail++; $display("FAIL loop_sh blk %0d got %b exp 01", k, u_if.DOUT_SH);
            end
            n_tests++;
            if ({u_if.DOUT_EN, u_if.BLOCK_LOCK, u_if.SLIP, u_if.SH_ERR} !== {1'b1, k >= 63, 2'b00}) begin
                n_fail++; $display("FAIL loop_flags blk %0d got %b exp %b", k,
                    {u_if.DOUT_EN, u_if.BLOCK_LOCK, u_if.SLIP, u_if.SH_ERR}, {1'b1, k >= 63, 2'b00});
            end
        end
    endtask

    task automatic test_self_sync();
        logic [63:0] p, scr, e;
        do_reset();
        tx_seed(1'b0);
        for (int k = 0; k < 20; k++) begin
            p = rnd64();
            scr = tx_scramble(p);
            e = model_desc(scr);
            step(1'b1, 2'b10, scr);
            n_tests++;
            if (u_if.DOUT !== e) begin
                n_fail++; $display("FAIL sync_model blk %0d got %h exp %h", k, u_if.DOUT, e);
            end
            if (k == 0) begin
                n_tests++;
                if (u_if.DOUT === p) begin
                    n_fail++; $display("FAIL sync_first blk 0 got %h exp not %h", u_if.DOUT, p);
                end
            end else begin
                n_tests++;
                if (u_if.DOUT !== p) begin
                    n_fail++; $display("FAIL sync_recover blk %0d got %h exp %h", k, u_if.DOUT, p);
                end
            end
        end
    endtask

    task automatic test_misaligned();
        logic [63:0] p, e;
        logic [1:0] sh;
        logic bad;
        do_reset();
        for (int k = 0; k < 70; k++) begin
            bad = (k == 0) || (k == 3);
            if (bad) sh = 2'b11;
            else if (k == 1 || k == 2 || k == 4 || k == 5) sh = 2'b00;
            else sh = rnd_valid_sh();
            p = rnd64();
            e = model_desc(p);
            step(1'b1, sh, p);
            n_tests++;
            if (u_if.DOUT !== e || u_if.DOUT_SH !== sh) begin
                n_fail++; $display("FAIL mis_data blk %0d got %h/%b exp %h/%b", k, u_if.DOUT, u_if.DOUT_SH, e, sh);
            end
            n_tests++;
            if ({u_if.DOUT_EN, u_if.BLOCK_LOCK, u_if.SLIP, u_if.SH_ERR} !== {1'b1, k == 69, bad, bad}) begin
                n_fail++; $display("FAIL mis_flags blk %0d got %b exp %b", k,
                    {u_if.DOUT_EN, u_if.BLOCK_LOCK, u_if.SLIP, u_if.SH_ERR}, {1'b1, k == 69, bad, bad});
            end
        end
    endtask

    // Runs straight after test_misaligned, so the window starts at the lock edge.
    task automatic test_locked_errors();
        logic [63:0] p, e;
        logic [1:0] sh;
        bit mask[64];
        int cnt, pulses, pos;
        logic e_lock, e_slip;
        for (int w = 0; w < 2; w++) begin
            foreach (mask[i]) mask[i] = 1'b0;
            cnt = 0;
            while (cnt < 15) begin
                pos = $urandom_range(0, 62);
                if (!mask[pos]) begin
                    mask[pos] = 1'b1;
                    cnt++;
                end
            end
            if (w == 1) mask[63] = 1'b1;
            pulses = 0;
            for (int k = 0; k < 64; k++) begin
                sh = mask[k] ? (($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11) : rnd_valid_sh();
                p = rnd64();
                e = model_desc(p);
                step(1'b1, sh, p);
                e_lock = (w == 0) || (k < 63);
                e_slip = (w == 1) && (k == 63);
                if (u_if.SH_ERR === 1'b1) pulses++;
                n_tests++;
                if (u_if.DOUT !== e) begin
                    n_fail++; $display("FAIL lock_dout win %0d blk %0d got %h exp %h", w, k, u_if.DOUT, e);
                end
                n_tests++;
                if ({u_if.DOUT_EN, u_if.BLOCK_LOCK, u_if.SLIP, u_if.SH_ERR} !== {1'b1, e_lock, e_slip, mask[k]}) begin
                    n_fail++; $display("FAIL lock_flags win %0d blk %0d got %b exp %b", w, k,
                        {u_if.DOUT_EN, u_if.BLOCK_LOCK, u_if.SLIP, u_if.SH_ERR}, {1'b1, e_lock, e_slip, mask[k]});
                end
            end
            n_tests++;
            if (pulses != 15 + w) begin
                n_fail++; $display("FAIL lock_pulses win %0d got %0d exp %0d", w, pulses, 15 + w);
            end
        end
        for (int k = 0; k < 2; k++) begin
            p = rnd64();
            e = model_desc(p);
            step(1'b1, 2'b00, p);
            n_tests++;
            if ({u_if.DOUT_EN, u_if.BLOCK_LOCK, u_if.SLIP, u_if.SH_ERR} !== 4'b1000) begin
                n_fail++; $display("FAIL lock_ignored blk %0d got %b exp 1000", k,
                    {u_if.DOUT_EN, u_if.BLOCK_LOCK, u_if.SLIP, u_if.SH_ERR});
            end
        end
    endtask

    task automatic test_gaps();
        logic [63:0] p, e, last;
        logic en;
        int n_en, c;
        do_reset();
        tx_seed(1'b1);
        n_en = 0;
        c = 0;
        last = '0;
        while (n_en < 66) begin
            en = (c % 3) != 2;
            if (en) begin
                p = rnd64();
                exp_q.push_back(p);
                step(1'b1, 2'b01, tx_scramble(p));
                n_en++;
                e = exp_q.pop_front();
                last = e;
            end else begin
                step(1'b0, 2'b00, rnd64());
                e = last;
            end
            n_tests++;
            if (u_if.DOUT !== e) begin
                n_fail++; $display("FAIL gap_dout cyc %0d got %h exp %h", c, u_if.DOUT, e);
            end
            n_tests++;
            if ({u_if.DOUT_EN, u_if.BLOCK_LOCK, u_if.SLIP, u_if.SH_ERR} !== {en, n_en >= 64, 2'b00}) begin
                n_fail++; $display("FAIL gap_flags cyc %0d got %b exp %b", c,
                    {u_if.DOUT_EN, u_if.BLOCK_LOCK, u_if.SLIP, u_if.SH_ERR}, {en, n_en >= 64, 2'b00});
            end
            c++;
        end
    endtask

    task automatic test_dis();
        logic [63:0] p, e;
        do_reset();
        u_if.CSR_PCS_DESCRAMB_DIS = 1'b1;
        for (int k = 0; k < 70; k++) begin
            p = (k == 5) ? 64'hDEADBEEF_01234567 : rnd64();
            step(1'b1, 2'b10, p);
            n_tests++;
            if (u_if.DOUT !== p) begin
                n_fail++; $display("FAIL dis_dout blk %0d got %h exp %h", k, u_if.DOUT, p);
            end
            n_tests++;
            if ({u_if.DOUT_EN, u_if.BLOCK_LOCK, u_if.SLIP, u_if.SH_ERR} !== {1'b1, k >= 63, 2'b00}) begin
                n_fail++; $display("FAIL dis_flags blk %0d got %b exp %b", k,
                    {u_if.DOUT_EN, u_if.BLOCK_LOCK, u_if.SLIP, u_if.SH_ERR}, {1'b1, k >= 63, 2'b00});
            end
        end
        u_if.CSR_PCS_DESCRAMB_DIS = 1'b0;
        for (int k = 0; k < 5; k++) begin
            p = rnd64();
            e = model_desc(p);
            step(1'b1, 2'b01, p);
            n_tests++;
            if (u_if.DOUT !== e || u_if.BLOCK_LOCK !== 1'b1) begin
                n_fail++; $display("FAIL dis_off blk %0d got %h/%b exp %h/1", k, u_if.DOUT, u_if.BLOCK_LOCK, e);
            end
        end
    endtask

    task automatic test_async_reset();
        n_tests++;
        if (u_if.BLOCK_LOCK !== 1'b1 || u_if.DOUT === 64'h0) begin
            n_fail++; $display("FAIL arst_pre got lock %b dout %h exp lock 1 dout nonzero", u_if.BLOCK_LOCK, u_if.DOUT);
        end
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if (u_if.DOUT !== 64'h0 || u_if.DOUT_SH !== 2'b00) begin
            n_fail++; $display("FAIL arst_data got %h/%b exp 0/00", u_if.DOUT, u_if.DOUT_SH);
        end
        n_tests++;
        if ({u_if.DOUT_EN, u_if.BLOCK_LOCK, u_if.SLIP, u_if.SH_ERR} !== 4'b0000) begin
            n_fail++; $display("FAIL arst_flags got %b exp 0000",
                {u_if.DOUT_EN, u_if.BLOCK_LOCK, u_if.SLIP, u_if.SH_ERR});
        end
        u_if.DIN_EN = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        u_if.CSR_PCS_DESCRAMB_DIS = 1'b0;
        u_if.DIN_EN = 1'b0;
        u_if.DIN = '0;
        test_reset();
        test_loopback();
        test_self_sync();
        test_misaligned();
        test_locked_errors();
        test_gaps();
        test_dis();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
